btn_input_ctrl: RTL and testbench

Parametrised multi-channel push-button front end for the game top level. It replaces the per-button debounce instances and hand-written edge logic. Each channel gets synchronisation, debouncing, press/release pulses, hold-to-repeat pulses for menu and debug stepping, and a tick-based hold-duration counter for jump charging. It sits between the board buttons and the character, block-generator and debug logic, all in the sys_clk domain.

---
 rtl/btn_input_ctrl.sv | 178 +++++++++++++++++
 tb/tb_btn_input_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_input_ctrl.sv
// ---------------------------------------------------------------------------
// btn_input_ctrl
//   Multi-channel push-button front end. Every channel is synchronised,
//   debounced, and turned into press/release pulses, hold-to-repeat pulses
//   and a tick-based hold-duration counter. Channels are independent lanes,
//   one btn_chan instance each.
//
//   Ports (all in the sys_clk domain except btn_raw):
//     sys_clk        system clock
//     sys_rst_n      asynchronous active-low reset
//     btn_raw        raw asynchronous button levels, 1 = pressed
//     tick           one-cycle hold-timing strobe
//     level          debounced level per channel
//     press          one-cycle pulse on accepted 0->1
//     release_pulse  one-cycle pulse on accepted 1->0
//     repeat_pulse   press pulse plus auto-repeat pulses while held
//     hold_cnt       ticks held; channel i at [i*HOLD_WIDTH +: HOLD_WIDTH]
//
//   'release' and 'repeat' are SystemVerilog keywords, so those two outputs
//   carry a _pulse suffix.
// ---------------------------------------------------------------------------

// Per-channel lane: sync -> debounce -> edge/repeat/hold logic.
// All outputs are registered; nothing combinational from raw or tick.
module btn_chan #(
  parameter int DB_CYCLES     = 1000000,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter bit REP_EN        = 1'b1,
  parameter int HOLD_WIDTH    = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  raw,
  input  logic                  tick,
  output logic                  level,
  output logic                  press,
  output logic                  release_pulse,
  output logic                  repeat_pulse,
  output logic [HOLD_WIDTH-1:0] hold_cnt
);

  localparam int DW   = $clog2(DB_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0]         DB_LAST  = DW'(DB_CYCLES - 1);
  localparam logic [RW-1:0]         RP_DLY   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]         RP_PER   = RW'(REPEAT_PERIOD - 1);
  localparam logic [HOLD_WIDTH-1:0] HOLD_MAX = '1;

  logic [1:0]    sync_q;
  logic          s;
  logic [DW-1:0] db_cnt;
  logic [RW-1:0] rp_cnt;
  logic          accept;
  logic          rise;
  logic          fall;

  assign s      = sync_q[1];
  // The new level is taken on the edge where the mismatch has lasted
  // DB_CYCLES samples; rise/fall qualify that same edge.
  assign accept = (s != level) && (db_cnt == DB_LAST);
  assign rise   = accept && !level;
  assign fall   = accept &&  level;

  // Two-flop synchroniser for the asynchronous button level.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) sync_q <= 2'b00;
    else            sync_q <= {sync_q[0], raw};
  end

  // Debounce: any return to equality restarts the count, so a glitch
  // shorter than DB_CYCLES never reaches the accept point.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      db_cnt        <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press         <= rise;
      release_pulse <= fall;
      if (s == level) begin
        db_cnt <= '0;
      end else if (accept) begin
        db_cnt <= '0;
        level  <= ~level;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Auto-repeat. rp_cnt counts down while held; at zero the next cycle
  // pulses and the period reloads. A release on the firing edge wins.
  // Masked lanes keep only the press pulse (the counter is then dead
  // logic and is trimmed by synthesis).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rp_cnt       <= '0;
      repeat_pulse <= 1'b0;
    end else if (rise) begin
      rp_cnt       <= RP_DLY;
      repeat_pulse <= 1'b1;
    end else if (level && !fall) begin
      if (rp_cnt == '0) begin
        rp_cnt       <= RP_PER;
        repeat_pulse <= REP_EN;
      end else begin
        rp_cnt       <= rp_cnt - 1'b1;
        repeat_pulse <= 1'b0;
      end
    end else begin
      rp_cnt       <= '0;
      repeat_pulse <= 1'b0;
    end
  end

  // Hold counter. Cleared on the press edge (beats a coincident tick);
  // the tick during the press-pulse cycle and a tick on the release edge
  // are not counted. Frozen while released so the charge can be read out.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_cnt <= '0;
    end else if (rise) begin
      hold_cnt <= '0;
    end else if (level && tick && !press && !fall && (hold_cnt != HOLD_MAX)) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

endmodule

module btn_input_ctrl #(
  parameter int               BTN_NUM       = 5,
  parameter int               DB_CYCLES     = 1000000,
  parameter int               REPEAT_DELAY  = 50000000,
  parameter int               REPEAT_PERIOD = 10000000,
  parameter logic [BTN_NUM-1:0] REPEAT_MASK = {BTN_NUM{1'b1}},
  parameter int               HOLD_WIDTH    = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic [BTN_NUM-1:0]            btn_raw,
  input  logic                          tick,
  output logic [BTN_NUM-1:0]            level,
  output logic [BTN_NUM-1:0]            press,
  output logic [BTN_NUM-1:0]            release_pulse,
  output logic [BTN_NUM-1:0]            repeat_pulse,
  output logic [BTN_NUM*HOLD_WIDTH-1:0] hold_cnt
);

  logic [BTN_NUM-1:0][HOLD_WIDTH-1:0] hold_lane;

  assign hold_cnt = hold_lane;

  for (genvar i = 0; i < BTN_NUM; i++) begin : g_chan
    btn_chan #(
      .DB_CYCLES     (DB_CYCLES),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .REP_EN        (REPEAT_MASK[i]),
      .HOLD_WIDTH    (HOLD_WIDTH)
    ) u_chan (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .raw           (btn_raw[i]),
      .tick          (tick),
      .level         (level[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i]),
      .hold_cnt      (hold_lane[i])
    );
  end

endmodule

// File: tb/tb_btn_input_ctrl.sv
// ---------------------------------------------------------------------------
// tb_btn_input_ctrl
//   Directed bench for btn_input_ctrl with BTN_NUM=2, DB_CYCLES=4,
//   REPEAT_DELAY=10, REPEAT_PERIOD=3, HOLD_WIDTH=4, REPEAT_MASK=2'b01.
//   Inputs are driven and outputs sampled 1 ns after each rising edge.
//   Loop index k counts edges after the raw change; raw edge -> level
//   is 6 edges (2 sync + 4 debounce).
// ---------------------------------------------------------------------------
module tb_btn_input_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [1:0] btn_raw;
  logic       tick;
  logic [1:0] level;
  logic [1:0] press;
  logic [1:0] release_pulse;
  logic [1:0] repeat_pulse;
  logic [7:0] hold_cnt;

  int n_assert = 0;
  int n_fail   = 0;
  int e0;
  int e1;

  btn_input_ctrl #(
    .BTN_NUM       (2),
    .DB_CYCLES     (4),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3),
    .REPEAT_MASK   (2'b01),
    .HOLD_WIDTH    (4)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .btn_raw       (btn_raw),
    .tick          (tick),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse),
    .hold_cnt      (hold_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    btn_raw   = 2'b00;
    tick      = 1'b0;

    // Reset state
    repeat (3) cyc();
    chk2("rst_level", level, 2'b00);
    chk2("rst_press", press, 2'b00);
    chk2("rst_release", release_pulse, 2'b00);
    chk2("rst_repeat", repeat_pulse, 2'b00);
    chk4("rst_hold0", hold_cnt[3:0], 4'd0);
    chk4("rst_hold1", hold_cnt[7:4], 4'd0);
    sys_rst_n = 1'b1;
    repeat (2) cyc();

    // Glitch: raw high for 3 sampled edges never gets accepted
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk2("glitch_level", level, 2'b00);
      chk2("glitch_press", press, 2'b00);
      chk2("glitch_repeat", repeat_pulse, 2'b00);
      if (k == 3) btn_raw[0] = 1'b0;
    end

    // Debounced press at k=6, repeats at 16,19,...,34; release driven so
    // that the release edge lands on the would-be repeat at 37.
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      cyc();
      chk2("rep_level", level, (k >= 6 && k < 37) ? 2'b01 : 2'b00);
      chk2("rep_press", press, (k == 6) ? 2'b01 : 2'b00);
      chk2("rep_repeat", repeat_pulse,
           (k == 6 || (k >= 16 && k < 37 && (k - 16) % 3 == 0)) ? 2'b01 : 2'b00);
      chk2("rep_release", release_pulse, (k == 37) ? 2'b01 : 2'b00);
      chk4("rep_hold0", hold_cnt[3:0], 4'd0);
      if (k == 31) btn_raw[0] = 1'b0;
    end
    repeat (3) cyc();

    // Masked channel 1: repeat only with the press pulse
    btn_raw[1] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      chk2("mask_level", level, (k >= 6 && k < 36) ? 2'b10 : 2'b00);
      chk2("mask_press", press, (k == 6) ? 2'b10 : 2'b00);
      chk2("mask_repeat", repeat_pulse, (k == 6) ? 2'b10 : 2'b00);
      chk2("mask_release", release_pulse, (k == 36) ? 2'b10 : 2'b00);
      if (k == 30) btn_raw[1] = 1'b0;
    end
    repeat (3) cyc();

    // Hold counter saturation: 40 ticks, every second cycle
    btn_raw[0] = 1'b1;
    repeat (6) cyc();
    chk2("hold_press", press, 2'b01);
    chk4("hold_start", hold_cnt[3:0], 4'd0);
    e0 = 0;
    for (int j = 0; j < 80; j++) begin
      tick = (j % 2 == 1);
      cyc();
      if (tick) e0 = (e0 < 15) ? e0 + 1 : 15;
      chk4("hold_count", hold_cnt[3:0], 4'(e0));
    end
    tick = 1'b0;
    chk4("hold_sat", hold_cnt[3:0], 4'd15);

    // Release: value stays at 15 while ticks keep coming
    btn_raw[0] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick = (k % 2 == 1);
      cyc();
      chk4("hold_frozen", hold_cnt[3:0], 4'd15);
      if (k == 6) chk2("hold_release", release_pulse, 2'b01);
    end
    tick = 1'b0;
    repeat (2) cyc();

    // Re-press with a tick sampled on the press edge: cleared to 0
    btn_raw[0] = 1'b1;
    tick       = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk4("repress_hold", hold_cnt[3:0], (k < 6) ? 4'd15 : 4'd0);
      if (k == 6) begin
        chk2("repress_press", press, 2'b01);
        tick = 1'b0;
      end
    end
    btn_raw[0] = 1'b0;
    repeat (10) cyc();

    // Simultaneous press; channel 1 releases while channel 0 stays held
    btn_raw = 2'b11;
    e0 = 0;
    e1 = 0;
    for (int k = 1; k <= 26; k++) begin
      cyc();
      if (tick) begin
        e0++;
        if (k <= 13) e1++;
      end
      chk2("sim_level", level,
           {(k >= 6 && k < 14), (k >= 6)});
      chk2("sim_press", press, (k == 6) ? 2'b11 : 2'b00);
      chk2("sim_release", release_pulse, (k == 14) ? 2'b10 : 2'b00);
      chk2("sim_repeat", repeat_pulse,
           {(k == 6), (k == 6 || (k >= 16 && (k - 16) % 3 == 0))});
      chk4("sim_hold0", hold_cnt[3:0], 4'(e0));
      chk4("sim_hold1", hold_cnt[7:4], 4'(e1));
      if (k == 8) btn_raw[1] = 1'b0;
      tick = (k >= 7 && k <= 12) || (k >= 15 && k <= 19);
    end
    tick = 1'b0;
    chk4("sim_hold0_final", hold_cnt[3:0], 4'd11);
    chk4("sim_hold1_final", hold_cnt[7:4], 4'd6);
    btn_raw = 2'b00;
    repeat (10) cyc();

    // Reset while held with hold_cnt = 5
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      tick = (k >= 7 && k <= 11);
    end
    tick = 1'b0;
    chk2("pre_rst_level", level, 2'b01);
    chk4("pre_rst_hold", hold_cnt[3:0], 4'd5);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk2("midrst_level", level, 2'b00);
    chk2("midrst_press", press, 2'b00);
    chk2("midrst_release", release_pulse, 2'b00);
    chk2("midrst_repeat", repeat_pulse, 2'b00);
    chk4("midrst_hold0", hold_cnt[3:0], 4'd0);
    chk4("midrst_hold1", hold_cnt[7:4], 4'd0);
    cyc();
    cyc();
    sys_rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk2("postrst_level", level, (k >= 6) ? 2'b01 : 2'b00);
      chk2("postrst_press", press, (k == 6) ? 2'b01 : 2'b00);
      chk2("postrst_repeat", repeat_pulse, (k == 6) ? 2'b01 : 2'b00);
      chk4("postrst_hold", hold_cnt[3:0], 4'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
